// File: rtl/ppl_skid_stage_pkg.sv
// Shared definitions for the elastic skid stage: state encodings (also used by the
// hazard/stall controller) and the occupancy decode helper.
package ppl_skid_stage_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_BUSY  = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    // The encoding value of each reachable state is its entry count.
    function automatic logic [1:0] occ_of_state(input skid_state_e st);
        logic [1:0] occ;
        case (st)
            SKID_EMPTY: occ = 2'd0;
            SKID_BUSY:  occ = 2'd1;
            SKID_FULL:  occ = 2'd2;
            default:    occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/ppl_skid_stage.sv
// Elastic pipeline stage: valid/ready register with a one-entry skid buffer, registered
// in_ready, synchronous flush and a saturating downstream-stall counter.
module ppl_skid_stage
    import ppl_skid_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_e       state_r;
    skid_state_e       state_fsm_s;
    skid_state_e       state_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] main_fsm_s;
    logic [DATA_W-1:0] main_s;
    logic [DATA_W-1:0] skid_r;
    logic [DATA_W-1:0] skid_fsm_s;
    logic [DATA_W-1:0] skid_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              stall_s;
    logic              cnt_sat_s;

    // Handshake outputs depend only on the state register, so out_ready never reaches in_ready.
    assign in_ready   = (state_r != SKID_FULL);
    assign out_valid  = (state_r != SKID_EMPTY);
    assign out_data   = main_r;
    assign occupancy  = occ_of_state(state_r);
    assign stall_cnt  = stall_cnt_r;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;
    assign stall_s    = out_valid & ~out_ready;
    assign cnt_sat_s  = (stall_cnt_r == {CNT_W{1'b1}});

    // Next-state and data-register steering for the unflushed case.
    always_comb begin
        state_fsm_s = state_r;
        main_fsm_s  = main_r;
        skid_fsm_s  = skid_r;
        case (state_r)
            SKID_EMPTY: begin
                if (in_fire_s) begin
                    state_fsm_s = SKID_BUSY;
                    main_fsm_s  = in_data;
                end else begin
                    state_fsm_s = SKID_EMPTY;
                end
            end
            SKID_BUSY: begin
                if (in_fire_s && out_fire_s) begin
                    state_fsm_s = SKID_BUSY;
                    main_fsm_s  = in_data;
                end else if (in_fire_s) begin
                    state_fsm_s = SKID_FULL;
                    skid_fsm_s  = in_data;
                end else if (out_fire_s) begin
                    state_fsm_s = SKID_EMPTY;
                end else begin
                    state_fsm_s = SKID_BUSY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only the downstream side can move.
                if (out_fire_s) begin
                    state_fsm_s = SKID_BUSY;
                    main_fsm_s  = skid_r;
                end else begin
                    state_fsm_s = SKID_FULL;
                end
            end
            default: begin
                state_fsm_s = SKID_EMPTY;
            end
        endcase
    end

    // Flush overrides the FSM and freezes the data registers so a squashed word is never captured.
    always_comb begin
        state_s = state_fsm_s;
        main_s  = main_fsm_s;
        skid_s  = skid_fsm_s;
        if (flush) begin
            state_s = SKID_EMPTY;
            main_s  = main_r;
            skid_s  = skid_r;
        end else begin
            state_s = state_fsm_s;
            main_s  = main_fsm_s;
            skid_s  = skid_fsm_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SKID_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Main and skid payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= {DATA_W{1'b0}};
            skid_r <= {DATA_W{1'b0}};
        end else begin
            main_r <= main_s;
            skid_r <= skid_s;
        end
    end

    // Saturating stall counter; flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && !cnt_sat_s) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_ppl_skid_stage.sv
// Randomised bench for ppl_skid_stage: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ppl_skid_stage;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready_a, out_valid_a;
    logic [DW-1:0] out_data_a;
    logic [1:0]    occ_a;
    logic [15:0]   stall_a;

    logic          in_ready_b, out_valid_b;
    logic [DW-1:0] out_data_b;
    logic [1:0]    occ_b;
    logic [3:0]    stall_b;

    ppl_skid_stage #(.DATA_W(DW), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .occupancy(occ_a), .stall_cnt(stall_a)
    );

    ppl_skid_stage #(.DATA_W(DW), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occupancy(occ_b), .stall_cnt(stall_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: FIFO contents and stall counts.
    logic [DW-1:0] mq[$];
    int            m_stall16 = 0;
    int            m_stall4  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each active edge; async reset clears everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_stall16 = 0;
            m_stall4  = 0;
        end else begin
            bit m_in_fire, m_out_fire;
            m_in_fire  = in_valid && (mq.size() < 2);
            m_out_fire = (mq.size() > 0) && out_ready;
            if ((mq.size() > 0) && !out_ready) begin
                if (m_stall16 < 65535) m_stall16++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_fire) void'(mq.pop_front());
                if (m_in_fire) mq.push_back(in_data);
            end
        end
    end

    // Compare both DUT instances against the model on the inactive edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready_a",  {31'd0, in_ready_a},  {31'd0, mq.size() < 2});
            chk("out_valid_a", {31'd0, out_valid_a}, {31'd0, mq.size() > 0});
            chk("occ_a",       {30'd0, occ_a},       mq.size());
            chk("stall_a",     {16'd0, stall_a},     m_stall16);
            chk("in_ready_b",  {31'd0, in_ready_b},  {31'd0, mq.size() < 2});
            chk("out_valid_b", {31'd0, out_valid_b}, {31'd0, mq.size() > 0});
            chk("occ_b",       {30'd0, occ_b},       mq.size());
            chk("stall_b",     {28'd0, stall_b},     m_stall4);
            if (mq.size() > 0) begin
                chk("out_data_a", out_data_a, mq[0]);
                chk("out_data_b", out_data_b, mq[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready_a},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid_a}, 32'd0);
        chk({tag, "_out_data"},  out_data_a,           32'd0);
        chk({tag, "_occ"},       {30'd0, occ_a},       32'd0);
        chk({tag, "_stall"},     {16'd0, stall_a},     32'd0);
        chk({tag, "_stall_b"},   {28'd0, stall_b},     32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        chk_en = 1'b1;

        // 1: reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            flush     = 1'($urandom);
            in_data   = $urandom;
            step();
        end
        chk_reset_vals("reset");
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step();

        // 2: streaming, one word per cycle, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11 + 32'(i);
            step();
            chk("stream_data", out_data_a, 32'h11 + 32'(i));
            chk("stream_occ",  {30'd0, occ_a}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_valid", {31'd0, out_valid_a}, 32'd0);

        // 3: backpressure fills the skid
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        chk("bp_first", out_data_a, 32'hA);
        in_data = 32'hB;
        step();
        chk("bp_occ", {30'd0, occ_a}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
        chk("bp_stall1", {16'd0, stall_a}, 32'd1);
        in_valid = 1'b0;
        step();
        step();
        chk("bp_hold", out_data_a, 32'hA);
        chk("bp_stall3", {16'd0, stall_a}, 32'd3);
        out_ready = 1'b1;
        step();
        chk("bp_second", out_data_a, 32'hB);
        chk("bp_stall_keep", {16'd0, stall_a}, 32'd3);
        step();
        chk("bp_empty", {31'd0, out_valid_a}, 32'd0);

        // 4: flush while FULL with a concurrent push of 0xC
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_data = 32'hC; flush = 1'b1;
        step();
        chk("flush_occ", {30'd0, occ_a}, 32'd0);
        chk("flush_valid", {31'd0, out_valid_a}, 32'd0);
        chk("flush_stall", {16'd0, stall_a}, 32'd5);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_no_c", {31'd0, out_valid_a}, 32'd0);
        chk("flush_stall_b", {28'd0, stall_b}, 32'd5);

        // 5: saturation of the 4-bit counter
        in_valid = 1'b1; in_data = 32'h5A;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_b", {28'd0, stall_b}, 32'd15);
        chk("sat_a", {16'd0, stall_a}, 32'd25);
        for (int i = 0; i < 3; i++) step();
        chk("sat_b_hold", {28'd0, stall_b}, 32'd15);
        chk("sat_a_more", {16'd0, stall_a}, 32'd28);

        // 6: async reset while FULL, between edges
        in_valid = 1'b1; in_data = 32'h77;
        step();
        chk("pre_rst_occ", {30'd0, occ_a}, 32'd2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        step();
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        step();
        chk("post_rst_data", out_data_a, 32'h55);
        chk("post_rst_valid", {31'd0, out_valid_a}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("post_rst_empty", {30'd0, occ_a}, 32'd0);

        // Random traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 3);
            in_data   = $urandom;
            step();
        end
        in_valid = 1'b0; flush = 1'b0;
        step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
